// File: rtl/frame_overlap_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_overlap_buffer_pkg                                                 |
// | Shared constants and encodings for the 50 % overlap framing stage.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package frame_overlap_buffer_pkg;

    localparam int FRAME_LEN = 128;
    localparam int HOP       = FRAME_LEN / 2;
    localparam int HANN_CW   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        STREAM = 2'd2
    } rd_state_e;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage
`default_nettype wire

// File: rtl/frame_overlap_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_overlap_buffer_if                                                  |
// | Sample input, frame-ready, readout request and burst output signals.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface frame_overlap_buffer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          ready_a;
    logic          ready_b;
    logic          rd_start_a;
    logic          rd_start_b;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_sel;
    logic          busy;
    logic          overrun;

    modport master (
        output in_valid, in_data, rd_start_a, rd_start_b,
        input  ready_a, ready_b, out_valid, out_data, out_last, out_sel, busy, overrun
    );

    modport slave (
        input  in_valid, in_data, rd_start_a, rd_start_b,
        output ready_a, ready_b, out_valid, out_data, out_last, out_sel, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fob_bank_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fob_bank_ram                                                             |
// | Ping-pong frame store: 2 x FRAME x DW, one write and one sync read port. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fob_bank_ram
    import frame_overlap_buffer_pkg::*;
#(
    parameter int DW    = 16,
    parameter int FRAME = FRAME_LEN
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [$clog2(FRAME):0]  waddr_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic                    re_i,
    input  logic [$clog2(FRAME):0]  raddr_i,
    output logic [DW-1:0]           rdata_o
);
    logic [DW-1:0] mem_q [2*FRAME];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end
endmodule
`default_nettype wire

// File: rtl/hann_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hann_rom                                                                 |
// | Registered Hann coefficient table, unsigned Q1.15 (FOB_HANN_WINDOW_EN).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifdef FOB_HANN_WINDOW_EN
module hann_rom
    import frame_overlap_buffer_pkg::*;
#(
    parameter int FRAME = FRAME_LEN
) (
    input  logic                       clk,
    input  logic [$clog2(FRAME)-1:0]   addr_i,
    output logic [HANN_CW-1:0]         coef_o
);
    logic [HANN_CW-1:0] rom [FRAME];

    for (genvar n = 0; n < FRAME; n++) begin : g_rom
        localparam real PHASE = 2.0 * 3.14159265358979 * real'(n) / real'(FRAME);
        localparam int  VAL   = $rtoi(0.5 * (1.0 - $cos(PHASE)) * 32768.0 + 0.5);
        assign rom[n] = HANN_CW'(VAL);
    end

    always_ff @(posedge clk) begin
        coef_o <= rom[addr_i];
    end
endmodule
`endif
`default_nettype wire

// File: rtl/frame_overlap_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_overlap_buffer                                                     |
// | Two 50 %-overlapped FRAME-sample streams, ping-pong banked, burst read.  |
// | Optional Hann windowing on readout: define FOB_HANN_WINDOW_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_overlap_buffer
    import frame_overlap_buffer_pkg::*;
#(
    parameter int DW    = 16,
    parameter int FRAME = FRAME_LEN
) (
    input  logic                  clk,
    input  logic                  n_rst,
    frame_overlap_buffer_if.slave bus
);
    localparam int AW = $clog2(FRAME);
    localparam logic [AW-1:0] c_last     = AW'(FRAME - 1);
    localparam logic [AW-1:0] c_hop_last = AW'(FRAME / 2 - 1);
    localparam logic [AW-1:0] c_hop      = AW'(FRAME / 2);

    logic [AW-1:0] cnt_q;
    logic          wa_q, wb_q, b_primed_q;
    logic [1:0]    full_a_q, full_a_d, full_b_q, full_b_d;
    rd_state_e     state_q, state_d;
    sel_e          rsel_q, rsel_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] ridx_q, ridx_d;
    logic          pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic          ready_a_q, ready_b_q, overrun_q, ovr_d;
    logic          rvalid_q, rlast_q, rsel_out_q;

    logic          w_done_a, w_done_b, w_issue, w_rd_end, w_rd_live;
    logic          w_req_a, w_req_b;
    logic [1:0]    w_avail_a, w_avail_b;
    logic [DW-1:0] w_rdata_a, w_rdata_b, w_rdata;

    assign w_done_a  = bus.in_valid && (cnt_q == c_last);
    assign w_done_b  = bus.in_valid && (cnt_q == c_hop_last) && b_primed_q;
    assign w_issue   = (state_q == ADDR) || (state_q == STREAM);
    assign w_rd_end  = (state_q == STREAM) && (ridx_q == c_last);
    assign w_rd_live = w_issue && !w_rd_end;

    // Full flags: readout completion frees its bank before completions are judged.
    always_comb begin : p_full
        w_avail_a = full_a_q;
        w_avail_b = full_b_q;
        if (w_rd_end) begin
            if (rsel_q == SEL_A) w_avail_a[rbank_q] = 1'b0;
            else                 w_avail_b[rbank_q] = 1'b0;
        end
        full_a_d = w_avail_a;
        full_b_d = w_avail_b;
        ovr_d    = 1'b0;
        if (w_done_a) begin
            full_a_d[wa_q] = 1'b1;
            if (w_avail_a[~wa_q] || (w_rd_live && rsel_q == SEL_A && rbank_q == ~wa_q)) begin
                ovr_d           = 1'b1;
                full_a_d[~wa_q] = 1'b0;
            end
        end
        if (w_done_b) begin
            full_b_d[wb_q] = 1'b1;
            if (w_avail_b[~wb_q] || (w_rd_live && rsel_q == SEL_B && rbank_q == ~wb_q)) begin
                ovr_d           = 1'b1;
                full_b_d[~wb_q] = 1'b0;
            end
        end
    end

    assign w_req_a = (bus.rd_start_a || pend_a_q) && (|w_avail_a);
    assign w_req_b = (bus.rd_start_b || pend_b_q) && (|w_avail_b);

    always_comb begin : p_fsm
        state_d  = state_q;
        rsel_d   = rsel_q;
        rbank_d  = rbank_q;
        ridx_d   = ridx_q;
        pend_a_d = pend_a_q || bus.rd_start_a;
        pend_b_d = pend_b_q || bus.rd_start_b;
        case (state_q)
            ADDR: begin
                ridx_d  = ridx_q + AW'(1);
                state_d = STREAM;
            end
            STREAM:  ridx_d = ridx_q + AW'(1);
            default: ;
        endcase
        // Arbitration point: idle, or the cycle issuing the final read of a burst.
        if (state_q == IDLE || w_rd_end) begin
            state_d  = IDLE;
            pend_a_d = w_req_a;
            pend_b_d = w_req_b;
            if (w_req_a) begin
                state_d  = ADDR;
                rsel_d   = SEL_A;
                rbank_d  = !w_avail_a[0];
                ridx_d   = '0;
                pend_a_d = 1'b0;
            end else if (w_req_b) begin
                state_d  = ADDR;
                rsel_d   = SEL_B;
                rbank_d  = !w_avail_b[0];
                ridx_d   = '0;
                pend_b_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q      <= '0;
            wa_q       <= 1'b0;
            wb_q       <= 1'b0;
            b_primed_q <= 1'b0;
            full_a_q   <= '0;
            full_b_q   <= '0;
            state_q    <= IDLE;
            rsel_q     <= SEL_A;
            rbank_q    <= 1'b0;
            ridx_q     <= '0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            ready_a_q  <= 1'b0;
            ready_b_q  <= 1'b0;
            overrun_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rsel_out_q <= 1'b0;
        end else begin
            if (bus.in_valid) cnt_q <= cnt_q + AW'(1);
            if (w_done_a)     wa_q  <= ~wa_q;
            if (w_done_b)     wb_q  <= ~wb_q;
            b_primed_q <= b_primed_q || w_done_a;
            full_a_q   <= full_a_d;
            full_b_q   <= full_b_d;
            state_q    <= state_d;
            rsel_q     <= rsel_d;
            rbank_q    <= rbank_d;
            ridx_q     <= ridx_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            ready_a_q  <= w_done_a;
            ready_b_q  <= w_done_b;
            overrun_q  <= ovr_d;
            rvalid_q   <= w_issue;
            rlast_q    <= w_rd_end;
            rsel_out_q <= rsel_q;
        end
    end

    fob_bank_ram #(.DW(DW), .FRAME(FRAME)) u_ram_a (
        .clk     (clk),
        .we_i    (bus.in_valid),
        .waddr_i ({wa_q, cnt_q}),
        .wdata_i (bus.in_data),
        .re_i    (w_issue && rsel_q == SEL_A),
        .raddr_i ({rbank_q, ridx_q}),
        .rdata_o (w_rdata_a)
    );

    fob_bank_ram #(.DW(DW), .FRAME(FRAME)) u_ram_b (
        .clk     (clk),
        .we_i    (bus.in_valid),
        .waddr_i ({wb_q, cnt_q ^ c_hop}),
        .wdata_i (bus.in_data),
        .re_i    (w_issue && rsel_q == SEL_B),
        .raddr_i ({rbank_q, ridx_q}),
        .rdata_o (w_rdata_b)
    );

    assign w_rdata   = rsel_out_q ? w_rdata_b : w_rdata_a;
    assign bus.ready_a = ready_a_q;
    assign bus.ready_b = ready_b_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = (state_q != IDLE) || pend_a_q || pend_b_q;

`ifdef FOB_HANN_WINDOW_EN
    localparam int PW = DW + HANN_CW + 1;
    localparam logic signed [PW-1:0] c_max = $signed(PW'(2 ** (DW - 1) - 1));
    localparam logic signed [PW-1:0] c_min = -c_max - $signed(PW'(1));

    logic [HANN_CW-1:0]     w_coef;
    logic signed [PW-1:0]   w_prod, w_scaled;
    logic [DW-1:0]          w_sat;
    logic                   win_valid_q, win_last_q, win_sel_q;
    logic [DW-1:0]          win_data_q;

    hann_rom #(.FRAME(FRAME)) u_rom (
        .clk    (clk),
        .addr_i (ridx_q),
        .coef_o (w_coef)
    );

    assign w_prod   = $signed(w_rdata) * $signed({1'b0, w_coef});
    assign w_scaled = w_prod >>> (HANN_CW - 1);

    always_comb begin : p_sat
        w_sat = w_scaled[DW-1:0];
        if (w_scaled > c_max)      w_sat = c_max[DW-1:0];
        else if (w_scaled < c_min) w_sat = c_min[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_sel_q   <= 1'b0;
            win_data_q  <= '0;
        end else begin
            win_valid_q <= rvalid_q;
            win_last_q  <= rlast_q;
            win_sel_q   <= rsel_out_q;
            win_data_q  <= rvalid_q ? w_sat : '0;
        end
    end

    assign bus.out_valid = win_valid_q;
    assign bus.out_data  = win_data_q;
    assign bus.out_last  = win_last_q;
    assign bus.out_sel   = win_sel_q;
`else
    assign bus.out_valid = rvalid_q;
    assign bus.out_data  = rvalid_q ? w_rdata : '0;
    assign bus.out_last  = rlast_q;
    assign bus.out_sel   = rsel_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_overlap_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_overlap_buffer                                                  |
// | Directed ramp, burst, overrun, empty-request and reset scenarios.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_frame_overlap_buffer;

    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_errors;
    int   pos;
    int   dofs;
    int   ovr_pos[$];

    frame_overlap_buffer_if #(.DW(16)) bus ();

    frame_overlap_buffer #(.DW(16), .FRAME(128)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_ovr(input int p);
        foreach (ovr_pos[i]) if (ovr_pos[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        n_rst          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.rd_start_a = 1'b0;
        bus.rd_start_b = 1'b0;
        cyc();
        cyc();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_ready_a", bus.ready_a, 0);
        check("rst_ready_b", bus.ready_b, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        n_rst = 1'b1;
        pos   = 0;
    endtask

    // pos counts samples since reset; a pulse follows the sample that completes a frame
    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(pos + dofs);
            cyc();
            check($sformatf("ready_a@%0d", pos), bus.ready_a, 32'((pos % 128) == 127));
            check($sformatf("ready_b@%0d", pos), bus.ready_b, 32'(((pos % 128) == 63) && (pos >= 128)));
            check($sformatf("overrun@%0d", pos), bus.overrun, 32'(is_ovr(pos)));
            pos++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_rd(input bit a, input bit b);
        bus.rd_start_a = a;
        bus.rd_start_b = b;
        cyc();
        bus.rd_start_a = 1'b0;
        bus.rd_start_b = 1'b0;
    endtask

    task automatic beats(input string nm, input bit sel, input int first, input int n, input bit busy_at_last);
        for (int k = 0; k < n; k++) begin
            cyc();
            check($sformatf("%s_valid%0d", nm, k), bus.out_valid, 1);
            check($sformatf("%s_data%0d", nm, k), bus.out_data, 32'(16'(first + k)));
            check($sformatf("%s_last%0d", nm, k), bus.out_last, 32'(k == 127));
            check($sformatf("%s_sel%0d", nm, k), bus.out_sel, 32'(sel));
            if (k < 127 || busy_at_last)
                check($sformatf("%s_busy%0d", nm, k), bus.busy, 1);
        end
    endtask

    task automatic idle_after(input string nm);
        cyc();
        check({nm, "_end_valid"}, bus.out_valid, 0);
        check({nm, "_end_busy"}, bus.busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        dofs     = 0;
        do_reset();

        // Empty request: no B frame exists yet
        pulse_rd(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("empty_valid%0d", i), bus.out_valid, 0);
            check($sformatf("empty_busy%0d", i), bus.busy, 0);
            cyc();
        end

        // Ramp with reads between completions
        feed(128);
        pulse_rd(1'b1, 1'b0);
        check("lat_a_t1_valid", bus.out_valid, 0);
        check("lat_a_t1_busy", bus.busy, 1);
        beats("rampA", 1'b0, 0, 128, 1'b0);
        idle_after("rampA");

        feed(64);
        pulse_rd(1'b0, 1'b1);
        check("lat_b_t1_valid", bus.out_valid, 0);
        beats("rampB", 1'b1, 64, 128, 1'b0);
        idle_after("rampB");

        feed(128);
        // Both streams full: A (128..255) then B (192..319) back to back
        pulse_rd(1'b1, 1'b1);
        check("sim_t1_valid", bus.out_valid, 0);
        check("sim_t1_busy", bus.busy, 1);
        beats("simA", 1'b0, 128, 128, 1'b1);
        beats("simB", 1'b1, 192, 128, 1'b0);
        idle_after("simB");

        // Overrun: 384 samples, no reads
        do_reset();
        ovr_pos = '{255, 319, 383};
        feed(384);
        ovr_pos = {};
        pulse_rd(1'b1, 1'b0);
        check("ovr_t1_valid", bus.out_valid, 0);
        beats("ovrA", 1'b0, 256, 128, 1'b0);
        idle_after("ovrA");

        // Reset during beat 50 of a B burst (B frame holds 192..319)
        pulse_rd(1'b0, 1'b1);
        beats("rstB", 1'b1, 192, 51, 1'b0);
        n_rst = 1'b0;
        cyc();
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_last", bus.out_last, 0);
        check("midrst_overrun", bus.overrun, 0);
        n_rst = 1'b1;
        pos   = 0;
        pulse_rd(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("postrst_valid%0d", i), bus.out_valid, 0);
            check($sformatf("postrst_busy%0d", i), bus.busy, 0);
            cyc();
        end
        dofs = 1000;
        feed(128);
        pulse_rd(1'b1, 1'b0);
        check("fresh_t1_valid", bus.out_valid, 0);
        beats("freshA", 1'b0, 1000, 128, 1'b0);
        idle_after("freshA");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_overlap_buffer.md
Name: frame_overlap_buffer

Overview:
- Upstream framing stage for the noise-canceller FFT path.
- Takes a single stream of audio samples and assembles two interleaved 128-sample frames with 50 % overlap: stream A on sample phase 0 and stream B offset by 64.
- Raises one-cycle ready pulses per stream; the FFT-start controller consumes these.
- On request from the controller, plays a completed frame out as a 128-beat burst into the FFT input mux.
- Each stream is ping-pong double-buffered, so writing continues while a frame is read out.

Parameters:
- DW, 16, sample and output data width (two's complement).
- FRAME, 128, frame length; must be a power of 2; hop is FRAME/2.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  sample strobe; one sample per asserted cycle.
- in_data  in  DW  input sample.
- ready_a  out  1  one-cycle pulse: a stream-A frame is complete.
- ready_b  out  1  one-cycle pulse: a stream-B frame is complete.
- rd_start_a  in  1  request readout of the completed stream-A frame.
- rd_start_b  in  1  request readout of the completed stream-B frame.
- out_valid  out  1  output beat valid.
- out_data  out  DW  output sample.
- out_last  out  1  marks beat FRAME-1 of a burst.
- out_sel  out  1  stream of the current burst: 0 = A, 1 = B.
- busy  out  1  a burst is active or a request is pending.
- overrun  out  1  one-cycle pulse: an unread frame was discarded.

Behaviour:
- Reset values: all outputs 0; sample counter cnt = 0; bank pointers = 0; full flags = 0; b_primed = 0; no pending request. Reset mid-burst aborts the burst; out_valid is low on the cycle after reset is sampled.
- Write path:
  - Each in_valid sample is written to A-bank[wa] at index cnt and to B-bank[wb] at index cnt XOR FRAME/2.
  - cnt then increments modulo FRAME.
- Stream A completion (write at cnt = FRAME-1):
  - Set full_a[wa], toggle wa, pulse ready_a on the next cycle.
- Stream B completion (write at cnt = FRAME/2-1):
  - Completes only if b_primed = 1; otherwise completion is suppressed, because the first B frame is partial.
  - b_primed is set on the first stream-A completion.
  - When it completes: set full_b[wb], toggle wb, pulse ready_b.
- Overrun: at any completion, if the newly selected write bank is still full or is under readout:
  - pulse overrun, clear that bank's full flag, and continue writing (the stale frame is lost).
  - If that bank is under readout, the burst completes with mixed data; that is acceptable and flagged.
- Read state machine: IDLE, ADDR, STREAM.
  - IDLE: if rd_start_a and full_a on some bank, go to ADDR for A. Otherwise if rd_start_b and full_b, go to ADDR for B.
  - A rd_start while the matching stream has no full bank is ignored; no burst, no error.
  - Simultaneous valid rd_start_a and rd_start_b: A is served first; B is latched pending and starts on the cycle after A's out_last.
  - A rd_start during STREAM is latched as pending (one per stream); a duplicate is discarded.
- Readout timing:
  - ADDR issues the synchronous memory read of index 0.
  - Latency: rd_start sampled at cycle T gives first out_valid at T+2. The burst is FRAME consecutive beats with no gaps; out_last is on the last beat.
  - out_sel is held for the whole burst.
  - The bank's full flag clears on out_last; the machine then returns to IDLE, or to ADDR if a request is pending.
- busy = (state != IDLE) or any pending request.
- in_valid and readout may coincide on every cycle; the memories are dual-port.

Optional Feature:
- Macro: FOB_HANN_WINDOW_EN.
- Defined:
  - out_data = (sample × hann[idx]) >>> (CW-1), where CW = 16 and the coefficient is unsigned Q1.15.
  - Rounding is truncation. The result is saturated to DW.
  - Adds exactly one pipeline cycle: first out_valid at T+3; out_last and out_sel are delayed to match.
- Undefined: raw samples; latency T+2; no multiplier or ROM is instantiated.

Decomposition:
- Shared package holds:
  - FRAME_LEN = 128, HOP = 64.
  - Read state enum (IDLE / ADDR / STREAM).
  - Stream-select encoding (SEL_A = 0, SEL_B = 1).
  - Hanning coefficient width.
- One sub-module: fob_bank_ram, a 2×FRAME×DW dual-port RAM with synchronous read. It is instantiated twice, once per stream.
- With FOB_HANN_WINDOW_EN, the ROM is a second small sub-module, hann_rom.

Test Plan:
- Ramp: in_data = 0..255 on consecutive in_valid cycles.
  - ready_a pulses after samples 127 and 255.
  - ready_b pulses only after sample 191, not after 63.
  - A readout after the first ready_a yields 0..127.
  - B readout yields 64..191.
- Latency: rd_start_a at cycle T gives out_valid from T+2 through T+129 and out_last at T+129 (macro off), or T+3 through T+130 (macro on).
- Simultaneous rd_start_a and rd_start_b with both frames full: A burst of 128, then B burst with no idle cycle between; out_sel goes 0 then 1; busy is high throughout.
- Overrun: feed 384 samples with no rd_start.
  - overrun pulses on the second A completion and again on the third.
  - A subsequent A read returns samples 256..383.
- Empty request: rd_start_b before any B completion gives no out_valid and busy stays 0.
- Reset: assert n_rst at beat 50 of a burst.
  - out_valid is 0 the next cycle and all flags clear.
  - The next ready_a appears only after 128 fresh samples.
